// File: rtl/id_hazard_ctl_pkg.sv
// Shared definitions for the decode-stage hazard controller: register widths,
// scoreboard geometry, entry layout, control modes and the source-match helper.
package id_hazard_ctl_pkg;

    localparam int unsigned REG_W    = 3;
    localparam int unsigned SB_DEPTH = 3;

    localparam int unsigned SB_EX  = 0;
    localparam int unsigned SB_MEM = 1;
    localparam int unsigned SB_WB  = 2;

    // Flat scoreboard entry layout: {v, rd, ld}
    localparam int unsigned SB_LD_BIT  = 0;
    localparam int unsigned SB_RD_LSB  = 1;
    localparam int unsigned SB_V_BIT   = REG_W + 1;
    localparam int unsigned SB_ENTRY_W = REG_W + 2;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             ld;
    } sb_entry_t;

    typedef enum logic [2:0] {
        ModeReset,
        ModeHalted,
        ModeStall,
        ModeFlush,
        ModeHazard,
        ModeRun
    } ctl_mode_t;

    function automatic logic sb_match(
        input sb_entry_t        e,
        input logic [REG_W-1:0] rs,
        input logic             rs_used,
        input logic [REG_W-1:0] rt,
        input logic             rt_used
    );
        return e.v & ((rs_used & (rs == e.rd)) | (rt_used & (rt == e.rd)));
    endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One scoreboard slot holding {v, rd, ld}; synchronous clear beats the hold enable.
module hazard_sb_stage
    import id_hazard_ctl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_v,
    input  logic [REG_W-1:0] i_rd,
    input  logic             i_ld,
    output logic             o_v,
    output logic [REG_W-1:0] o_rd,
    output logic             o_ld
);

    logic [SB_ENTRY_W-1:0] r_entry;
    logic [SB_ENTRY_W-1:0] w_entry_in;

    always_comb begin
        w_entry_in                       = '0;
        w_entry_in[SB_V_BIT]             = i_v;
        w_entry_in[SB_RD_LSB +: REG_W]   = i_rd;
        w_entry_in[SB_LD_BIT]            = i_ld;
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_entry <= '0;
        end else if (i_en) begin
            r_entry <= w_entry_in;
        end
    end

    assign o_v  = r_entry[SB_V_BIT];
    assign o_rd = r_entry[SB_RD_LSB +: REG_W];
    assign o_ld = r_entry[SB_LD_BIT];

endmodule

// File: rtl/id_hazard_ctl.sv
// Decode-stage hazard/flow controller with an EX/MEM/WB destination scoreboard.
// Define HAZARD_FWD_EN when full EX/MEM forwarding exists (load-use stalls only).
module id_hazard_ctl
    import id_hazard_ctl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic             i_id_rs_used,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_rt_used,
    input  logic [REG_W-1:0] i_id_rd,
    input  logic             i_id_regwrite,
    input  logic             i_id_memread,
    input  logic             i_id_halt,
    input  logic             i_ex_flush,
    input  logic             i_mem_stall,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_pipe_hold,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    sb_entry_t        w_sb [SB_DEPTH];
    sb_entry_t        w_sb_new;
    logic             w_hazard;
    ctl_mode_t        w_mode;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;
    logic             w_unused;

    always_comb begin
        w_hazard = 1'b0;
`ifdef HAZARD_FWD_EN
        w_hazard = i_id_valid & w_sb[SB_EX].ld
                 & sb_match(w_sb[SB_EX], i_id_rs, i_id_rs_used, i_id_rt, i_id_rt_used);
`else
        // WB producers are covered by the register file's write-before-read
        w_hazard = i_id_valid
                 & (sb_match(w_sb[SB_EX], i_id_rs, i_id_rs_used, i_id_rt, i_id_rt_used)
                  | sb_match(w_sb[SB_MEM], i_id_rs, i_id_rs_used, i_id_rt, i_id_rt_used));
`endif
    end

    always_comb begin
        if (i_rst) begin
            w_mode = ModeReset;
        end else if (r_halted) begin
            w_mode = ModeHalted;
        end else if (i_mem_stall) begin
            w_mode = ModeStall;
        end else if (i_ex_flush) begin
            w_mode = ModeFlush;
        end else if (w_hazard) begin
            w_mode = ModeHazard;
        end else begin
            w_mode = ModeRun;
        end
    end

    always_comb begin
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_en    = 1'b0;
        o_pipe_hold  = 1'b0;
        unique case (w_mode)
            ModeReset:  o_ifid_flush = 1'b1;
            ModeHalted: o_pipe_hold  = i_mem_stall;
            ModeStall:  o_pipe_hold  = 1'b1;
            ModeFlush: begin
                o_pc_en      = 1'b1;
                o_ifid_en    = 1'b1;
                o_ifid_flush = 1'b1;
            end
            ModeHazard: ;
            ModeRun: begin
                o_pc_en   = 1'b1;
                o_ifid_en = 1'b1;
                o_idex_en = i_id_valid;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_sb_new    = '0;
        w_sb_new.v  = o_idex_en & i_id_regwrite;
        w_sb_new.rd = i_id_rd;
        w_sb_new.ld = i_id_memread;
    end

    for (genvar g = 0; g < SB_DEPTH; g++) begin : g_sb
        logic             w_v_in;
        logic [REG_W-1:0] w_rd_in;
        logic             w_ld_in;

        if (g == 0) begin : g_head
            assign w_v_in  = w_sb_new.v;
            assign w_rd_in = w_sb_new.rd;
            assign w_ld_in = w_sb_new.ld;
        end else begin : g_tail
            assign w_v_in  = w_sb[g-1].v;
            assign w_rd_in = w_sb[g-1].rd;
            assign w_ld_in = w_sb[g-1].ld;
        end

        hazard_sb_stage u_stage (
            .i_clk (i_clk),
            .i_clr (i_rst),
            .i_en  (~i_mem_stall),
            .i_v   (w_v_in),
            .i_rd  (w_rd_in),
            .i_ld  (w_ld_in),
            .o_v   (w_sb[g].v),
            .o_rd  (w_sb[g].rd),
            .o_ld  (w_sb[g].ld)
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_halted <= 1'b0;
        end else if (o_idex_en & i_id_halt) begin
            r_halted <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if ((w_mode == ModeHazard) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if ((w_mode == ModeFlush) && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
        end
    end

    assign o_halted       = r_halted;
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

    // The WB slot only mirrors retirement; it never gates issue
    assign w_unused = ^{w_sb[SB_WB], w_sb[SB_MEM]};

endmodule
